muldiv_iter: RTL and testbench

MULDIV_ITER -- requirements
Module: muldiv_iter

---
 rtl/muldiv_iter.sv | 140 ++++++++++++++
 tb/tb_muldiv_iter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with signed fix-up in a final correction step.
module muldiv_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] hi_bits,
  output logic [WIDTH-1:0] lo_bits,
  output logic             div0,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           op_q;
  logic                 sign_a, sign_b, div0_q, ovf_q;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   prod;
  logic [CNT_W-1:0]     cnt;

  logic                 in_sa, in_sb, in_div0, in_ovf;
  logic [WIDTH-1:0]     in_ma, in_mb;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   mul_step, div_step, prod_neg;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  // Operand conditioning at the accept point: signs, magnitudes, special cases
  always_comb begin
    in_sa   = op[0] & opA[WIDTH-1];
    in_sb   = op[0] & opB[WIDTH-1];
    in_ma   = in_sa ? -opA : opA;
    in_mb   = in_sb ? -opB : opB;
    in_div0 = op[1] && (opB == '0);
    in_ovf  = (op == 2'b11) && (opA == {1'b1, {(WIDTH-1){1'b0}}}) && (opB == '1);
  end

  // Both algorithms keep the running value in prod: {partial/remainder, shifting operand}
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_b} : '0);
    mul_step  = {mul_sum, prod[WIDTH-1:1]};
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    div_ge    = div_shift >= {1'b0, mag_b};
    div_step  = {div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0],
                 prod[WIDTH-2:0], div_ge};
    prod_neg  = -prod;
  end

  always_comb begin
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (div0_q) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (op_q[1]) begin
      fix_lo = (sign_a ^ sign_b) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
      fix_hi = sign_a ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    end else if (sign_a ^ sign_b) begin
      fix_hi = prod_neg[2*WIDTH-1:WIDTH];
      fix_lo = prod_neg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = in_div0 ? FIX : CALC;
      end
      CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      mag_b   <= '0;
      prod    <= '0;
      cnt     <= '0;
      hi_bits <= '0;
      lo_bits <= '0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          op_q   <= op;
          sign_a <= in_sa;
          sign_b <= in_sb;
          div0_q <= in_div0;
          ovf_q  <= in_ovf;
          mag_b  <= in_mb;
          cnt    <= '0;
          // Divide-by-zero result is preloaded so FIX can pass it straight through
          prod   <= in_div0 ? {opA, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, in_ma};
        end
        CALC: begin
          cnt  <= cnt + 1'b1;
          prod <= op_q[1] ? div_step : mul_step;
        end
        FIX: begin
          hi_bits <= fix_hi;
          lo_bits <= fix_lo;
          div0    <= div0_q;
          ovf     <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter (WIDTH=16): expected results are modelled
// with native SV arithmetic, queued at issue and compared on the done pulse.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op_sel = 2'b00;
  logic [15:0] op_a = '0, op_b = '0;
  logic        ready, done, div0, ovf;
  logic [15:0] hi_bits, lo_bits;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        d0;
    logic        ov;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  muldiv_iter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_sel), .opA(op_a), .opB(op_b),
    .ready(ready), .done(done), .hi_bits(hi_bits), .lo_bits(lo_bits),
    .div0(div0), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    if (obs !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [31:0] p;
    logic signed [15:0] sa, sb;
    sa = a;
    sb = b;
    e.d0 = 1'b0; e.ov = 1'b0; e.lat = 18;
    e.hi = '0; e.lo = '0;
    case (o)
      2'b00: begin p = {16'h0, a} * {16'h0, b}; e.hi = p[31:16]; e.lo = p[15:0]; end
      2'b01: begin
        p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
        e.hi = p[31:16]; e.lo = p[15:0];
      end
      default: begin
        if (b == 16'h0) begin
          e.hi = a; e.lo = 16'hFFFF; e.d0 = 1'b1; e.lat = 2;
        end else if (o == 2'b10) begin
          e.lo = a / b; e.hi = a % b;
        end else if (a == 16'h8000 && b == 16'hFFFF) begin
          e.lo = 16'h8000; e.hi = 16'h0000; e.ov = 1'b1;
        end else begin
          e.lo = sa / sb; e.hi = sa % sb;
        end
      end
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input logic [1:0] o, input logic [15:0] a,
                               input logic [15:0] b, input bit busy_pulse);
    exp_t e;
    int edges, guard, ready_bad, extra;
    exp_q.push_back(model(o, a, b));
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 50) begin @(negedge clk); guard++; end
    start = 1'b1; op_sel = o; op_a = a; op_b = b;
    @(posedge clk); #1;
    edges = 1;
    ready_bad = 0;
    if (busy_pulse) begin
      op_sel = 2'b00; op_a = 16'h5555; op_b = 16'h0003;
    end else start = 1'b0;
    while (!done && edges < 100) begin
      if (ready) ready_bad++;
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    checkOutput("doneSeen", {31'h0, done}, 32'h1);
    checkOutput("latency", edges, e.lat);
    checkOutput("readyBusy", ready_bad, 0);
    checkOutput("hi", {16'h0, hi_bits}, {16'h0, e.hi});
    checkOutput("lo", {16'h0, lo_bits}, {16'h0, e.lo});
    checkOutput("div0", {31'h0, div0}, {31'h0, e.d0});
    checkOutput("ovf", {31'h0, ovf}, {31'h0, e.ov});
    @(posedge clk); #1;
    checkOutput("donePulse", {31'h0, done}, 32'h0);
    checkOutput("readyAfter", {31'h0, ready}, 32'h1);
    if (busy_pulse) begin
      extra = 0;
      repeat (25) begin @(posedge clk); #1; if (done) extra++; end
      checkOutput("busyStartIgnored", extra, 0);
    end
  endtask

  initial begin
    int extra;
    logic [1:0]  ro;
    logic [15:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReady", {31'h0, ready}, 32'h1);
    checkOutput("rstDone", {31'h0, done}, 32'h0);
    checkOutput("rstHi", {16'h0, hi_bits}, 32'h0);
    checkOutput("rstLo", {16'h0, lo_bits}, 32'h0);
    checkOutput("rstDiv0", {31'h0, div0}, 32'h0);
    checkOutput("rstOvf", {31'h0, ovf}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
    applyStimulus(2'b01, 16'hFFFD, 16'h0005, 1'b0);
    applyStimulus(2'b10, 16'h0064, 16'h0007, 1'b0);
    applyStimulus(2'b11, 16'hFFF9, 16'h0002, 1'b0);
    applyStimulus(2'b11, 16'h8000, 16'hFFFF, 1'b0);
    applyStimulus(2'b10, 16'h1234, 16'h0000, 1'b1);

    // Abort a multiply mid-iteration; outputs must clear without a clock edge
    @(negedge clk);
    start = 1'b1; op_sel = 2'b00; op_a = 16'h1234; op_b = 16'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abortHi", {16'h0, hi_bits}, 32'h0);
    checkOutput("abortLo", {16'h0, lo_bits}, 32'h0);
    checkOutput("abortDiv0", {31'h0, div0}, 32'h0);
    checkOutput("abortReady", {31'h0, ready}, 32'h1);
    checkOutput("abortDone", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (25) begin @(posedge clk); #1; if (done) extra++; end
    checkOutput("abortNoDone", extra, 0);
    applyStimulus(2'b00, 16'h0003, 16'h0004, 1'b0);

    repeat (8) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = 16'($urandom);
      applyStimulus(ro, ra, rb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
